la_spram_ecc: RTL and testbench
===============================

# la_spram_ecc

Single-port synchronous RAM with SECDED error correction, per-bit write mask via read-modify-write, and a valid/ready request port with in-order responses. It is the next generation of the generic single-port RAM for designs that need protected on-chip storage. It carries the same hard-macro pass-through (`PROP`, `ctrl`, `test`, power pins), and the ECC wraps the storage array.

## Interface
Parameters:
- `DW`, 32: data width.
- `AW`, 10: address width; depth is 2**AW.
- `PROP`, "DEFAULT": hard-macro selector, passed through to the storage array.
- `CTRLW`, 1: ctrl width.
- `TESTW`, 1: test width.
- Derived `PW`: smallest p with 2**p >= DW+p+1, plus 1 overall-parity bit (DW=32 gives PW=7). Stored word is DW+PW bits.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on edges where `req_valid & req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_wmask` in DW: per-bit write mask.
- `req_addr` in AW: word address.
- `req_din` in DW: write data.
- `req_inj` in 2: error injection on write. 01 flips codeword bit 0; 11 flips bits 0 and 1; 10 does nothing.
- `rsp_valid` out 1: one-cycle pulse, one per accepted request.
- `rsp_dout` out DW: corrected read data, or the data written.
- `rsp_cerr` out 1: single-bit error corrected.
- `rsp_uerr` out 1: uncorrectable error.
- `cnt_cerr` out 16: saturating count of corrected errors.
- `cnt_uerr` out 16: saturating count of uncorrectable errors.
- `vss`, `vdd`, `vddio` in 1: power pins.
- `ctrl` in CTRLW, `test` in TESTW: pass-through to the storage array.

## Operation
FSM states:
- IDLE: `req_ready`=1.
- RMW: `req_ready`=0, one cycle only. Always returns to IDLE.

Request handling:
- **Read:** array is read at the accept edge. The output is decoded and corrected, then registered to the `rsp_*` outputs.
- **Full write** (`req_wmask` all ones): the word is encoded and written at the accept edge. `rsp_dout` = `req_din`.
- **Partial write** (mask not all ones and not zero):
  - At the accept edge: array read, then go to RMW.
  - During RMW: decode the old word and merge `din&wmask | old&~wmask`.
  - At the next edge: re-encode and write, then return to IDLE. `rsp_dout` = merged word.
  - If the old word is uncorrectable, the write is suppressed: `rsp_uerr`=1, `rsp_dout`=0.
- **Zero-mask write:** no array access. Response carries `rsp_dout`=0 and no error flags.
- **Injection:** applies to the full encoded codeword, after any merge.
- **Error flags:**
  - On writes, `rsp_cerr`/`rsp_uerr` report only the RMW pre-read.
  - A syndrome pointing at a check bit counts as `cerr`; data is unchanged.
  - Nonzero syndrome with even overall parity means `uerr`.
- **Counters:** increment by 1 on each response carrying the corresponding flag. Both hold at 0xFFFF.

Out-of-scope behaviour:
- No response backpressure; the consumer must accept every `rsp_valid`.
- Array contents are not reset. Reads of never-written words produce undefined data and flags; benches must initialise before checking.

## Timing
Reset values, with `rst` sampled high at an edge:
- `rsp_valid`=0, `rsp_dout`=0, `rsp_cerr`=0, `rsp_uerr`=0.
- `cnt_cerr`=0, `cnt_uerr`=0.
- FSM in IDLE. `req_ready`=0 while `rst`=1 and 1 afterwards.

Latency and throughput:
- Read, full write and zero-mask write: accept at edge k, `rsp_valid` high in the cycle after edge k+1. Throughput is one per clock.
- Partial write: accept at edge k, write at edge k+1, `rsp_valid` in the cycle after edge k+2. `req_ready` is low in the cycle between k and k+1.
- Responses are strictly in acceptance order.

Ordering and reset corner cases:
- Read-after-write to the same address on back-to-back edges returns the new data, because the write lands at the earlier edge.
- `rst` during RMW aborts the pending write: no array write, no response.
- A response already registered is cleared by reset.
- Requests presented while `req_ready`=0 are ignored; the requester must hold them.

## Structure
Shared include (`la_ecc_pkg`):
- `PW` computation function.
- Syndrome-to-bit-position mapping.
- Codeword bit-ordering constants.

Sub-module `la_secded`: combinational, parameterised by DW.
- Encoder: DW to DW+PW.
- Decoder: outputs corrected data, `cerr`, `uerr`.
- Instantiated twice: once for encode, once for decode.

Storage:
- The array is the existing single-port RAM at width DW+PW with mask all ones.
- `PROP`, `ctrl`, `test` and the power pins pass straight through to it.

Top level holds the FSM, merge datapath, response registers and counters.

## Test plan
- **Full write then read:** write 0xDEADBEEF to addr 5; read addr 5.
  - Write response: `rsp_dout`=0xDEADBEEF, no flags.
  - Read response: 0xDEADBEEF on the cycle after the second edge.
- **Partial write:** 0xFFFFFFFF at addr 3; then write `din`=0x00000000, mask 0x0000FF00.
  - `req_ready` drops for 1 cycle.
  - Read of addr 3 returns 0xFFFF00FF.
- **Single-bit injection:** write 0x12345678 with `req_inj`=01; read.
  - Returns 0x12345678 with `rsp_cerr`=1 and `cnt_cerr`=1.
  - A partial write to the same address also reports `cerr` and writes back a clean codeword; the next read has no flags.
- **Double-bit injection:** write with `req_inj`=11; read.
  - Read: `rsp_uerr`=1, `cnt_uerr`=1.
  - Partial write to that address: suppressed, `rsp_uerr`=1, `rsp_dout`=0; the word is still uncorrectable afterwards.
- **Back-to-back:** alternate 8 reads and full writes with `req_valid` held high.
  - One response per cycle, in order, with data matching a reference model.
- **Reset mid-RMW and counter saturation:**
  - Assert `rst` in the RMW cycle: no response, and the old word is intact.
  - Force 65537 single-bit errors: `cnt_cerr` holds at 0xFFFF.

Source files
------------

// File: rtl/la_ecc_pkg.sv
// Shared SECDED definitions: check-bit sizing, codeword layout, FSM and request encodings.
package la_ecc_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_RMW = 1'b1} state_t;
  typedef enum logic [1:0] {RK_RD, RK_FULL, RK_PART, RK_ZERO} kind_t;

  // Codeword bit 0 is the overall parity; bits 1..N are Hamming positions,
  // with check bits at the power-of-two positions.
  localparam int CW_PAR = 0;

  function automatic int calc_pw(input int dw);
    int p = 1;
    while ((1 << p) < dw + p + 1) p++;
    return p + 1;
  endfunction

  // Hamming position of data bit j: skip every power of two at or below it.
  function automatic int data_pos(input int j);
    int pos = j + 1;
    for (int k = 0; k < 16; k++)
      if ((1 << k) <= pos) pos++;
    return pos;
  endfunction

endpackage

// File: rtl/la_secded.sv
// Combinational SECDED encoder and decoder over a DW-bit data word.
module la_secded
  import la_ecc_pkg::*;
#(
  parameter int DW = 32,
  localparam int PW = calc_pw(DW),
  localparam int CW = DW + PW
) (
  input  logic [DW-1:0] enc_d,
  output logic [CW-1:0] enc_cw,
  input  logic [CW-1:0] dec_cw,
  output logic [DW-1:0] dec_d,
  output logic          dec_cerr,
  output logic          dec_uerr
);
  localparam int N  = CW - 1;
  localparam int SW = PW - 1;

  logic [SW-1:0] syn;
  logic          par;
  logic [CW-1:0] fix;

  always_comb begin
    enc_cw = '0;
    for (int j = 0; j < DW; j++) enc_cw[data_pos(j)] = enc_d[j];
    for (int k = 0; k < SW; k++)
      for (int i = 1; i <= N; i++)
        if (((i >> k) & 1) != 0 && i != (1 << k))
          enc_cw[1 << k] = enc_cw[1 << k] ^ enc_cw[i];
    enc_cw[CW_PAR] = ^enc_cw[N:1];
  end

  always_comb begin
    syn = '0;
    for (int i = 1; i <= N; i++)
      if (dec_cw[i]) syn = syn ^ SW'(i);
    par      = ^dec_cw;
    fix      = dec_cw;
    dec_cerr = 1'b0;
    dec_uerr = 1'b0;
    // Odd parity = single flip; syndrome 0 means the parity bit itself.
    if (par) begin
      if (int'(syn) <= N) begin
        dec_cerr = 1'b1;
        for (int i = 0; i <= N; i++)
          if (int'(syn) == i) fix[i] = ~fix[i];
      end else begin
        dec_uerr = 1'b1;
      end
    end else if (syn != '0) begin
      dec_uerr = 1'b1;
    end
    dec_d = '0;
    for (int j = 0; j < DW; j++) dec_d[j] = fix[data_pos(j)];
  end

endmodule

// File: rtl/la_spram.sv
// Generic single-port synchronous RAM; hard-macro controls and power pins are accepted for drop-in use.
module la_spram #(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter     PROP  = "DEFAULT",
  parameter int CTRLW = 1,
  parameter int TESTW = 1
) (
  input  logic             clk,
  input  logic             ce,
  input  logic             we,
  input  logic [DW-1:0]    wmask,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  input  logic             vss,
  input  logic             vdd,
  input  logic             vddio,
  input  logic [CTRLW-1:0] ctrl,
  input  logic [TESTW-1:0] test
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (ce) begin
      if (we) mem[addr] <= (din & wmask) | (mem[addr] & ~wmask);
      dout <= mem[addr];
    end

endmodule

// File: rtl/la_spram_ecc.sv
// SECDED-protected single-port RAM with valid/ready requests, masked writes via
// read-modify-write, error injection and saturating error counters.
module la_spram_ecc
  import la_ecc_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter     PROP  = "DEFAULT",
  parameter int CTRLW = 1,
  parameter int TESTW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [DW-1:0]    req_wmask,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_din,
  input  logic [1:0]       req_inj,
  output logic             rsp_valid,
  output logic [DW-1:0]    rsp_dout,
  output logic             rsp_cerr,
  output logic             rsp_uerr,
  output logic [15:0]      cnt_cerr,
  output logic [15:0]      cnt_uerr,
  input  logic             vss,
  input  logic             vdd,
  input  logic             vddio,
  input  logic [CTRLW-1:0] ctrl,
  input  logic [TESTW-1:0] test
);
  localparam int CW = DW + calc_pw(DW);

  state_t          state, state_nxt;
  kind_t           req_kind, s1_kind;
  logic            acc, rmw;
  logic            s1_vld, s2_vld, s2_cerr, s2_uerr;
  logic [DW-1:0]   s1_din, s1_wmask, s2_dout;
  logic [1:0]      s1_inj, inj;
  logic [AW-1:0]   s1_addr, arr_addr;
  logic [DW-1:0]   enc_d, dec_d, merged;
  logic [CW-1:0]   enc_cw, arr_din, arr_dout;
  logic            dec_cerr, dec_uerr, arr_ce, arr_we;
  logic            nxt_vld, nxt_cerr, nxt_uerr;
  logic [DW-1:0]   nxt_dout;

  always_comb begin
    if (!req_we)              req_kind = RK_RD;
    else if (&req_wmask)      req_kind = RK_FULL;
    else if (|req_wmask)      req_kind = RK_PART;
    else                      req_kind = RK_ZERO;
  end

  // FSM: state register / next state / outputs
  always_ff @(posedge clk)
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (acc && req_kind == RK_PART) state_nxt = ST_RMW;
      ST_RMW:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE) && !rst;
    rmw       = (state == ST_RMW);
  end

  assign acc = req_valid & req_ready;

  // One shared write port: fresh data in IDLE, merged word during RMW.
  always_comb begin
    merged   = (s1_din & s1_wmask) | (dec_d & ~s1_wmask);
    enc_d    = rmw ? merged  : req_din;
    inj      = rmw ? s1_inj  : req_inj;
    arr_addr = rmw ? s1_addr : req_addr;
    arr_din  = enc_cw ^ {{(CW-2){1'b0}}, inj[1] & inj[0], inj[0]};
    arr_ce   = !rst && (rmw || (acc && req_kind != RK_ZERO));
    arr_we   = !rst && (rmw ? !dec_uerr : (acc && req_kind == RK_FULL));
  end

  la_secded #(.DW(DW)) u_enc (
    .enc_d(enc_d), .enc_cw(enc_cw),
    .dec_cw('0), .dec_d(), .dec_cerr(), .dec_uerr()
  );

  la_secded #(.DW(DW)) u_dec (
    .enc_d('0), .enc_cw(),
    .dec_cw(arr_dout), .dec_d(dec_d), .dec_cerr(dec_cerr), .dec_uerr(dec_uerr)
  );

  la_spram #(.DW(CW), .AW(AW), .PROP(PROP), .CTRLW(CTRLW), .TESTW(TESTW)) u_ram (
    .clk(clk), .ce(arr_ce), .we(arr_we), .wmask({CW{1'b1}}), .addr(arr_addr),
    .din(arr_din), .dout(arr_dout), .vss(vss), .vdd(vdd), .vddio(vddio),
    .ctrl(ctrl), .test(test)
  );

  always_ff @(posedge clk)
    if (rst) s1_vld <= 1'b0;
    else     s1_vld <= acc;

  always_ff @(posedge clk)
    if (acc) begin
      s1_kind  <= req_kind;
      s1_din   <= req_din;
      s1_wmask <= req_wmask;
      s1_inj   <= req_inj;
      s1_addr  <= req_addr;
    end

  // Partial writes respond one edge after the RMW write lands.
  always_ff @(posedge clk)
    if (rst) s2_vld <= 1'b0;
    else     s2_vld <= rmw;

  always_ff @(posedge clk)
    if (rmw) begin
      s2_dout <= dec_uerr ? '0 : merged;
      s2_cerr <= dec_cerr;
      s2_uerr <= dec_uerr;
    end

  always_comb begin
    nxt_vld  = s2_vld | (s1_vld && s1_kind != RK_PART);
    nxt_dout = '0;
    nxt_cerr = 1'b0;
    nxt_uerr = 1'b0;
    if (s2_vld) begin
      nxt_dout = s2_dout;
      nxt_cerr = s2_cerr;
      nxt_uerr = s2_uerr;
    end else if (s1_vld) begin
      case (s1_kind)
        RK_RD:   begin nxt_dout = dec_d; nxt_cerr = dec_cerr; nxt_uerr = dec_uerr; end
        RK_FULL: nxt_dout = s1_din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_dout  <= '0;
      rsp_cerr  <= 1'b0;
      rsp_uerr  <= 1'b0;
      cnt_cerr  <= '0;
      cnt_uerr  <= '0;
    end else begin
      rsp_valid <= nxt_vld;
      rsp_dout  <= nxt_dout;
      rsp_cerr  <= nxt_vld & nxt_cerr;
      rsp_uerr  <= nxt_vld & nxt_uerr;
      if (nxt_vld && nxt_cerr && cnt_cerr != 16'hFFFF) cnt_cerr <= cnt_cerr + 16'd1;
      if (nxt_vld && nxt_uerr && cnt_uerr != 16'hFFFF) cnt_uerr <= cnt_uerr + 16'd1;
    end

endmodule

// File: tb/tb_la_spram_ecc.sv
// Bench for la_spram_ecc: per-address word/error-state model, in-order expectation queue.
module tb_la_spram_ecc;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_wmask, req_din;
  logic [9:0]  req_addr;
  logic [1:0]  req_inj;
  logic        rsp_valid, rsp_cerr, rsp_uerr;
  logic [31:0] rsp_dout;
  logic [15:0] cnt_cerr, cnt_uerr;

  la_spram_ecc dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_wmask(req_wmask), .req_addr(req_addr), .req_din(req_din),
    .req_inj(req_inj), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .rsp_cerr(rsp_cerr), .rsp_uerr(rsp_uerr), .cnt_cerr(cnt_cerr), .cnt_uerr(cnt_uerr),
    .vss(1'b0), .vdd(1'b1), .vddio(1'b1), .ctrl(1'b0), .test(1'b0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: word contents plus an error state (0 clean, 1 one flip, 2 two flips).
  typedef struct {
    int          due;
    logic [31:0] d;
    bit          chk_d;
    bit          ce, ue;
    logic [15:0] cc, cu;
  } exp_t;

  exp_t        q[$];
  logic [31:0] md [int];
  int          me [int];
  logic [15:0] mc = 0, mu = 0;

  logic [31:0] last_dout = 0;
  logic        last_ce = 0, last_ue = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) chk("rsp_spurious", 1, 0);
      else begin
        e = q.pop_front();
        chk("rsp_cycle", cyc, e.due);
        if (e.chk_d) chk("rsp_dout", rsp_dout, e.d);
        chk("rsp_cerr", rsp_cerr, e.ce);
        chk("rsp_uerr", rsp_uerr, e.ue);
        chk("cnt_cerr", cnt_cerr, e.cc);
        chk("cnt_uerr", cnt_uerr, e.cu);
      end
      last_dout = rsp_dout;
      last_ce   = rsp_cerr;
      last_ue   = rsp_uerr;
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      chk("rsp_missing", 0, 1);
      void'(q.pop_front());
    end
  end

  function automatic int inj_state(input logic [1:0] inj);
    return (inj == 2'b01) ? 1 : (inj == 2'b11) ? 2 : 0;
  endfunction

  // Present a request at a negedge, hold it until accepted, return at the negedge after.
  task automatic issue(input bit we, input logic [31:0] m, input int a,
                       input logic [31:0] d, input logic [1:0] inj, input bit track = 1'b1);
    exp_t e;
    int   w   = 0;
    int   lat = 2;
    req_valid = 1'b1; req_we = we; req_wmask = m; req_addr = 10'(a);
    req_din = d; req_inj = inj;
    while (req_ready !== 1'b1 && w < 8) begin @(negedge clk); w++; end
    if (req_ready !== 1'b1) chk("accept_timeout", 0, 1);
    if (track) begin
      e.d = 0; e.chk_d = 1'b1; e.ce = 1'b0; e.ue = 1'b0;
      if (!we) begin
        e.d = md[a]; e.ce = (me[a] == 1); e.ue = (me[a] == 2); e.chk_d = (me[a] != 2);
      end else if (m == 32'hFFFF_FFFF) begin
        md[a] = d; me[a] = inj_state(inj); e.d = d;
      end else if (m != 0) begin
        lat = 3;
        if (me[a] == 2) e.ue = 1'b1;
        else begin
          e.ce  = (me[a] == 1);
          md[a] = (d & m) | (md[a] & ~m);
          me[a] = inj_state(inj);
          e.d   = md[a];
        end
      end
      if (e.ce && mc != 16'hFFFF) mc++;
      if (e.ue && mu != 16'hFFFF) mu++;
      e.cc = mc; e.cu = mu; e.due = cyc + lat;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int w = 0;
    req_valid = 1'b0;
    while (q.size() > 0 && w < 20) begin @(negedge clk); w++; end
    if (q.size() > 0) begin chk("drain_timeout", q.size(), 0); q.delete(); end
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_wmask = '0;
    req_addr = '0; req_din = '0; req_inj = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dout", rsp_dout, 0);
    chk("rst_flags", {rsp_cerr, rsp_uerr}, 0);
    chk("rst_cnt_cerr", cnt_cerr, 0);
    chk("rst_cnt_uerr", cnt_uerr, 0);
    chk("rst_ready_low", req_ready, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", req_ready, 1);
    @(negedge clk);

    // full write, read back, zero-mask write leaves the word alone
    issue(1, '1, 5, 32'hDEADBEEF, 2'b00); drain();
    chk("lit_wr_dout", last_dout, 32'hDEADBEEF);
    chk("lit_wr_flags", {last_ce, last_ue}, 0);
    issue(0, '1, 5, 0, 2'b00); drain();
    chk("lit_rd5", last_dout, 32'hDEADBEEF);
    issue(1, 32'h0, 5, 32'hFFFFFFFF, 2'b00); drain();
    chk("lit_zero_dout", last_dout, 0);
    issue(0, '1, 5, 0, 2'b00); drain();
    chk("lit_rd5_after_zero", last_dout, 32'hDEADBEEF);

    // partial write through RMW
    issue(1, '1, 3, 32'hFFFFFFFF, 2'b00);
    issue(1, 32'h0000FF00, 3, 32'h0, 2'b00);
    chk("ready_low_in_rmw", req_ready, 0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("ready_back", req_ready, 1);
    issue(0, '1, 3, 0, 2'b00); drain();
    chk("lit_partial", last_dout, 32'hFFFF00FF);

    // single-bit injection, then scrub by partial write
    issue(1, '1, 4, 32'h12345678, 2'b01);
    issue(0, '1, 4, 0, 2'b00); drain();
    chk("lit_sbe_dout", last_dout, 32'h12345678);
    chk("lit_sbe_cerr", last_ce, 1);
    chk("lit_sbe_cnt", cnt_cerr, 1);
    issue(1, 32'h000000FF, 4, 32'h000000AB, 2'b00); drain();
    chk("lit_sbe_rmw_cerr", last_ce, 1);
    chk("lit_sbe_rmw_dout", last_dout, 32'h123456AB);
    issue(0, '1, 4, 0, 2'b00); drain();
    chk("lit_scrubbed", {last_ce, last_ue}, 0);

    // double-bit injection; partial write must be suppressed
    issue(1, '1, 6, 32'hCAFEF00D, 2'b11);
    issue(0, '1, 6, 0, 2'b00); drain();
    chk("lit_dbe_uerr", last_ue, 1);
    chk("lit_dbe_cnt", cnt_uerr, 1);
    issue(1, 32'h000000FF, 6, 32'h00000055, 2'b00); drain();
    chk("lit_dbe_rmw_uerr", last_ue, 1);
    chk("lit_dbe_rmw_dout", last_dout, 0);
    issue(0, '1, 6, 0, 2'b00); drain();
    chk("lit_dbe_still", last_ue, 1);
    chk("lit_dbe_cnt3", cnt_uerr, 3);

    // back-to-back alternating full writes and reads, valid held high
    for (int i = 0; i < 4; i++) begin
      issue(1, '1, 16 + i, 32'h1111_1111 * (i + 1), 2'b10);
      issue(0, '1, 16 + i, 0, 2'b00);
    end
    drain();
    chk("lit_b2b_last", last_dout, 32'h4444_4444);

    // reset in the RMW cycle aborts the write and produces no response
    issue(1, '1, 7, 32'hA5A5A5A5, 2'b00); drain();
    issue(1, 32'h000000FF, 7, 32'h0, 2'b00, 1'b0);
    rst = 1'b1; req_valid = 1'b0; mc = 0; mu = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("rmw_rst_no_rsp", rsp_valid, 0);
    repeat (3) @(negedge clk);
    chk("rmw_rst_cnt", {cnt_cerr, cnt_uerr}, 0);
    issue(0, '1, 7, 0, 2'b00); drain();
    chk("lit_rmw_rst_old", last_dout, 32'hA5A5A5A5);

    // counter saturation
    issue(1, '1, 9, 32'h0F0F0F0F, 2'b01);
    for (int i = 0; i < 65537; i++) issue(0, '1, 9, 0, 2'b00);
    drain();
    chk("lit_cnt_sat", cnt_cerr, 16'hFFFF);
    chk("lit_cnt_uerr_zero", cnt_uerr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
